// File: rtl/exu_pkg.sv
// Shared constants and state encoding for the exu_mc execute unit.
package exu_pkg;

  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_REG     = 7'b0110011;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/exu_shift_step.sv
// One combinational shift step of k bits, left or right, logical or arithmetic.
// Arithmetic right shifts replicate the current MSB; the caller keeps the MSB equal
// to the original sign bit, so every step fills with the original sign.
module exu_shift_step #(
  parameter int XLEN = 32,
  parameter int KW   = 6
) (
  input  logic [XLEN-1:0] value,
  input  logic [KW-1:0]   k,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  // select shift direction and fill
  always_comb begin
    result = value;
    if (left)
      result = value << k;
    else if (arith)
      result = $signed(value) >>> k;
    else
      result = value >> k;
  end

endmodule

// File: rtl/exu_mc.sv
// Multi-cycle RV32I/RV64I OP-IMM/OP execute unit with valid/ready on both sides.
// Single-cycle ALU ops, iterative shifts (SHIFT_STEP bits per cycle).
// Build option: define EXU_MUL_EN to add an iterative shift-add MUL (XLEN cycles).
//
// state | meaning
// IDLE  | ready to accept an operation
// SHIFT | iterating a shift, rem bits still to go
// MUL   | iterating shift-add multiply, rem multiplier bits still to go
// DONE  | result held on out_* until out_ready
module exu_mc import exu_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [11:0]     in_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] STEP_K  = RW'(SHIFT_STEP);
  localparam logic [RW-1:0] MUL_CNT = RW'(XLEN);
  // imm[11:SW] pattern of a legal SRAI (F7_ALT, minus any bit that belongs to shamt)
  localparam logic [11-SW:0] IMM_SRA_HI = (12-SW)'(F7_ALT >> (SW-5));

  state_t state, state_nx;

  logic [XLEN-1:0] opb, alu_res, work, step_res;
  logic [SW-1:0]   shamt;
  logic [11-SW:0]  imm_hi;
  logic [RW-1:0]   rem, step_k;
  logic [4:0]      rd_q;
  logic            is_imm, is_reg, is_shift, is_mul, sh_alt, illegal;
  logic            ill_q, sh_left, sh_arith;

  // decode and single-cycle ALU on the offered operation
  always_comb begin
    is_imm   = (in_op == OP_IMM);
    is_reg   = (in_op == OP_REG);
    opb      = is_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_src2;
    shamt    = opb[SW-1:0];
    imm_hi   = in_imm[11:SW];
    is_shift = (in_funct3 == F3_SLL) || (in_funct3 == F3_SR);
    sh_alt   = is_imm ? in_imm[10] : in_funct7[5];
    is_mul   = 1'b0;
    illegal  = 1'b0;
    if (is_imm) begin
      if (in_funct3 == F3_SLL)
        illegal = (imm_hi != '0);
      else if (in_funct3 == F3_SR)
        illegal = (imm_hi != '0) && (imm_hi != IMM_SRA_HI);
    end else if (is_reg) begin
      case (in_funct7)
        F7_BASE: illegal = 1'b0;
        F7_ALT:  illegal = !((in_funct3 == F3_ADD) || (in_funct3 == F3_SR));
`ifdef EXU_MUL_EN
        F7_MULDIV: begin
          illegal = (in_funct3 != F3_ADD);
          is_mul  = (in_funct3 == F3_ADD);
        end
`endif
        default: illegal = 1'b1;
      endcase
    end else begin
      illegal = 1'b1;
    end

    case (in_funct3)
      F3_ADD:  alu_res = (is_reg && in_funct7 == F7_ALT) ? in_src1 - opb : in_src1 + opb;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(opb))};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < opb)};
      F3_XOR:  alu_res = in_src1 ^ opb;
      F3_OR:   alu_res = in_src1 | opb;
      F3_AND:  alu_res = in_src1 & opb;
      default: alu_res = in_src1;  // shifts start from src1
    endcase
    if (illegal || is_mul)
      alu_res = '0;  // MUL accumulator starts at zero
  end

  assign step_k = (rem < STEP_K) ? rem : STEP_K;

  exu_shift_step #(.XLEN(XLEN), .KW(RW)) u_step (
    .value  (work),
    .k      (step_k),
    .left   (sh_left),
    .arith  (sh_arith),
    .result (step_res)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) begin
        if (illegal)                        state_nx = DONE;
        else if (is_mul)                    state_nx = MUL;
        else if (is_shift && shamt != '0)   state_nx = SHIFT;
        else                                state_nx = DONE;
      end
      SHIFT: if (rem <= STEP_K)     state_nx = DONE;
      MUL:   if (rem == RW'(1))     state_nx = DONE;
      DONE:  if (out_ready)         state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign out_result  = work;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;

`ifdef EXU_MUL_EN
  logic [XLEN-1:0] mcand, mplier;

  // multiplicand/multiplier shift registers for shift-add multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand  <= in_src1;
      mplier <= in_src2;
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`endif

  // capture on accept, then iterate the working register
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      rd_q     <= '0;
      ill_q    <= 1'b0;
      rem      <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work     <= alu_res;
          rd_q     <= in_rd;
          ill_q    <= illegal;
          rem      <= is_mul ? MUL_CNT : RW'(shamt);
          sh_left  <= (in_funct3 == F3_SLL);
          sh_arith <= sh_alt;
        end
        SHIFT: begin
          work <= step_res;
          rem  <= rem - step_k;
        end
`ifdef EXU_MUL_EN
        MUL: begin
          if (mplier[0]) work <= work + mcand;
          rem <= rem - RW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_mc.sv
// Self-checking bench for exu_mc: two instances (SHIFT_STEP=1 and 8) driven in lockstep,
// compared against an arithmetic reference model.
module tb_exu_mc;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
`ifdef EXU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [6:0]  in_op, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_src1, in_src2;
  logic [11:0] in_imm;
  logic [4:0]  in_rd;

  logic        rdy1, ov1, ill1, rdy8, ov8, ill8;
  logic [31:0] res1, res8;
  logic [4:0]  rd1, rd8;

  int errors = 0;
  int checks = 0;
  int obs_lat1, obs_lat8;
  logic [31:0] obs_res1;
  logic obs_ill1;

  always #5 clk = ~clk;

  exu_mc #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_rd(in_rd), .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_rd(rd1), .out_illegal(ill1));

  exu_mc #(.XLEN(32), .SHIFT_STEP(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_rd(in_rd), .out_valid(ov8), .out_ready(out_ready),
    .out_result(res8), .out_rd(rd8), .out_illegal(ill8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: result, legality and latency straight from the ISA rules
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] s2, input logic [11:0] imm,
                                input int step, output logic [31:0] res, output logic ill,
                                output int lat);
    logic [31:0] b;
    int sh;
    logic alt;
    b   = (op == OPI) ? {{20{imm[11]}}, imm} : s2;
    sh  = int'(b[4:0]);
    res = 32'h0;
    lat = 1;
    ill = 1'b0;
    if (op == OPI) begin
      if (f3 == 3'd1)      ill = (imm[11:5] != 7'h00);
      else if (f3 == 3'd5) ill = !(imm[11:5] == 7'h00 || imm[11:5] == 7'h20);
    end else if (op == OPR) begin
      if (f7 == 7'h20)      ill = !(f3 == 3'd0 || f3 == 3'd5);
      else if (f7 == 7'h01) ill = !(MUL_ON && f3 == 3'd0);
      else if (f7 != 7'h00) ill = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (ill) return;
    alt = (op == OPI) ? imm[10] : f7[5];
    case (f3)
      3'd0: begin
        if (op == OPR && f7 == 7'h01) begin res = a * s2; lat = 33; end
        else if (op == OPR && f7 == 7'h20) res = a - b;
        else res = a + b;
      end
      3'd1: begin res = a << sh; lat = 1 + (sh + step - 1) / step; end
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: begin
        res = alt ? 32'($signed(a) >>> sh) : (a >> sh);
        lat = 1 + (sh + step - 1) / step;
      end
      3'd6: res = a | b;
      default: res = a & b;
    endcase
  endfunction

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [11:0] imm,
                        input logic [4:0] rd);
    logic [31:0] e_res, e_res8;
    logic e_ill, e_ill8;
    int e_lat1, e_lat8, n;
    bit s1, s8;
    model(op, f3, f7, a, b, imm, 1, e_res, e_ill, e_lat1);
    model(op, f3, f7, a, b, imm, 8, e_res8, e_ill8, e_lat8);
    @(negedge clk);
    in_op = op; in_funct3 = f3; in_funct7 = f7; in_src1 = a; in_src2 = b;
    in_imm = imm; in_rd = rd; in_valid = 1'b1; out_ready = 1'b1;
    chk("accept_ready1", rdy1, 1);
    chk("accept_ready8", rdy8, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0; s1 = 0; s8 = 0;
    while (!(s1 && s8) && n < 200) begin
      @(negedge clk);
      n++;
      if (!s1 && ov1) begin
        s1 = 1; obs_lat1 = n; obs_res1 = res1; obs_ill1 = ill1;
        chk("res1", res1, e_res);
        chk("ill1", ill1, e_ill);
        chk("rd1", rd1, rd);
        chk("lat1", n, e_lat1);
      end
      if (!s8 && ov8) begin
        s8 = 1; obs_lat8 = n;
        chk("res8", res8, e_res8);
        chk("ill8", ill8, e_ill8);
        chk("rd8", rd8, rd);
        chk("lat8", n, e_lat8);
      end
    end
    chk("done_seen1", s1, 1);
    chk("done_seen8", s8, 1);
    @(negedge clk);
    chk("idle_ready1", rdy1, 1);
    chk("idle_ready8", rdy8, 1);
  endtask

  initial begin
    bit seen;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [11:0] imm;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_funct3 = '0;
    in_funct7 = '0; in_src1 = '0; in_src2 = '0; in_imm = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready1", rdy1, 1);       chk("rst_ready8", rdy8, 1);
    chk("rst_valid1", ov1, 0);        chk("rst_valid8", ov8, 0);
    chk("rst_result1", res1, 0);      chk("rst_result8", res8, 0);
    chk("rst_rd1", rd1, 0);           chk("rst_illegal1", ill1, 0);
    rst = 1'b0;

    run_op(OPI, 3'd0, 7'h00, 32'h10, 32'h0, 12'hFFF, 5'd1);
    chk("addi_res", obs_res1, 32'h0000000F);
    chk("addi_lat", obs_lat1, 1);
    chk("addi_ill", obs_ill1, 0);

    run_op(OPI, 3'd5, 7'h20, 32'h80000000, 32'h0, 12'h41F, 5'd2);
    chk("srai_res", obs_res1, 32'hFFFFFFFF);
    chk("srai_lat_step1", obs_lat1, 32);
    chk("srai_lat_step8", obs_lat8, 5);

    run_op(OPR, 3'd2, 7'h00, 32'hFFFFFFFF, 32'h1, 12'h0, 5'd3);
    chk("slt_res", obs_res1, 32'h1);
    run_op(OPR, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h1, 12'h0, 5'd3);
    chk("sltu_res", obs_res1, 32'h0);
    run_op(OPR, 3'd0, 7'h20, 32'h0, 32'h1, 12'h0, 5'd4);
    chk("sub_res", obs_res1, 32'hFFFFFFFF);

    run_op(7'h7F, 3'd0, 7'h00, 32'h5, 32'h5, 12'h5, 5'd5);
    chk("illegal_flag", obs_ill1, 1);
    chk("illegal_res", obs_res1, 0);
    chk("illegal_lat", obs_lat1, 1);

    run_op(OPI, 3'd1, 7'h00, 32'hA5A5A5A5, 32'h0, 12'h000, 5'd6);
    chk("shamt0_lat8", obs_lat8, 1);

    run_op(OPR, 3'd0, 7'h01, 32'hFFFFFFFF, 32'h3, 12'h0, 5'd9);
    if (MUL_ON) begin
      chk("mul_res", obs_res1, 32'hFFFFFFFD);
      chk("mul_lat", obs_lat1, 33);
    end else begin
      chk("mul_illegal", obs_ill1, 1);
    end

    // backpressure: result held, in_valid ignored while busy
    @(negedge clk);
    in_op = OPI; in_funct3 = 3'd0; in_imm = 12'h008; in_src1 = 32'h12345670;
    in_rd = 5'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid1", ov1, 1);          chk("bp_valid8", ov8, 1);
      chk("bp_res1", res1, 32'h12345678); chk("bp_res8", res8, 32'h12345678);
      chk("bp_rd1", rd1, 7);              chk("bp_ready1", rdy1, 0);
      chk("bp_ready8", rdy8, 0);
      in_valid = (k % 2 == 0); in_src1 = $urandom; in_rd = 5'd3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_hold_res1", res1, 32'h12345678);
    chk("bp_hold_rd8", rd8, 7);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready1", rdy1, 1);
    chk("bp_release_valid1", ov1, 0);
    chk("bp_release_ready8", rdy8, 1);

    // reset during SHIFT drops the operation
    @(negedge clk);
    in_op = OPI; in_funct3 = 3'd5; in_imm = 12'h41F; in_src1 = 32'h80000000;
    in_rd = 5'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready1", rdy1, 1);   chk("rst_mid_ready8", rdy8, 1);
    chk("rst_mid_valid1", ov1, 0);    chk("rst_mid_valid8", ov8, 0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov1 || ov8) seen = 1;
    end
    chk("rst_mid_no_result", seen, 0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OPI;
        4, 5, 6, 7: op = OPR;
        default:    op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      imm = 12'($urandom);
      if (op == OPI && (f3 == 3'd1 || f3 == 3'd5)) begin
        case ($urandom_range(0, 2))
          0: imm[11:5] = 7'h00;
          1: imm[11:5] = 7'h20;
          default: ;
        endcase
      end
      run_op(op, f3, f7, $urandom, $urandom, imm, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
